// File: rtl/bp_pkg.sv
// -----------------------------------------------------------------------------
// bp_pkg
// Definitions shared by the branch-resolution pipeline and the global
// predictor:
//   - BP_ADDR_W            default PC / target address width
//   - PHT_DEPTH, GHR_WIDTH predictor geometry (used by the predictor side)
//   - br_info_t            per-instruction branch bookkeeping record
//   - sat_inc32()          saturating 32-bit increment for statistics
// -----------------------------------------------------------------------------
package bp_pkg;

    localparam int BP_ADDR_W = 32;
    localparam int PHT_DEPTH = 1024;
    localparam int GHR_WIDTH = 10;

    // valid    : slot holds a real conditional branch (0 = bubble)
    // pred     : prediction attached in F
    // taken    : actual outcome, filled in when leaving E
    // target   : taken target address
    // pc_plus8 : fall-through address
    typedef struct packed {
        logic                 valid;
        logic                 pred;
        logic                 taken;
        logic [BP_ADDR_W-1:0] target;
        logic [BP_ADDR_W-1:0] pc_plus8;
    } br_info_t;

    // Counter increment that sticks at all-ones instead of wrapping.
    function automatic logic [31:0] sat_inc32(input logic [31:0] value);
        logic [31:0] result;
        if (value == 32'hFFFF_FFFF) begin
            result = value;
        end else begin
            result = value + 32'd1;
        end
        return result;
    endfunction

endpackage

// File: rtl/bp_stage_reg.sv
// -----------------------------------------------------------------------------
// bp_stage_reg
// One pipeline register for a branch record, with hold and bubble controls.
// The record type is a parameter so the top level can pass a record whose
// address fields match its own ADDR_W; the default is bp_pkg::br_info_t.
//
// Ports:
//   clk    in   rising-edge clock
//   rst_n  in   asynchronous active-low reset, clears the record
//   stall  in   hold the current contents
//   flush  in   load an all-zero record (bubble); wins over stall
//   d      in   next record
//   q      out  registered record
// -----------------------------------------------------------------------------
module bp_stage_reg
    import bp_pkg::*;
#(
    parameter type info_t = br_info_t
) (
    input  logic  clk,
    input  logic  rst_n,
    input  logic  stall,
    input  logic  flush,
    input  info_t d,
    output info_t q
);

    // Stage register: reset/flush give a fully zeroed bubble so every field,
    // not only valid, is deterministic downstream.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q <= '0;
        end else if (flush) begin
            q <= '0;
        end else if (!stall) begin
            q <= d;
        end else begin
            q <= q;
        end
    end

endmodule

// File: rtl/bp_resolve.sv
// -----------------------------------------------------------------------------
// bp_resolve
// Carries the global predictor's taken/not-taken guess alongside a
// conditional branch from F through D and E, and resolves it in M against
// the outcome computed in E. On a misprediction it reports the correct
// next fetch PC and drives the predictor update port.
//
// Optional feature: define BP_STATS_EN to build saturating branch and
// mispredict counters. Without it the counter outputs are constant 0 and
// no counter state exists.
//
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   pcsrcPF               prediction for the instruction in F
//   branchD               instruction in D is a conditional branch
//   targetD, pc_plus8D    taken target / fall-through of the instruction in D
//   takenE                actual branch condition resolved in E
//   stallD, stallE        hold F->D and D->E registers
//   flushD, flushE,flushM bubble F->D, D->E, E->M registers
//   pcsrcPD               prediction attached to the instruction in D
//   branchM, pcsrcM,
//   pcsrcPM               valid branch in M, actual outcome, carried guess
//   mispredictM           misprediction resolved in M
//   redirect_pcM          correct next fetch PC for the M entry
//   branch_cnt,
//   mispred_cnt           statistics counters
// -----------------------------------------------------------------------------
module bp_resolve
    import bp_pkg::*;
#(
    parameter int ADDR_W = BP_ADDR_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              pcsrcPF,
    input  logic              branchD,
    input  logic [ADDR_W-1:0] targetD,
    input  logic [ADDR_W-1:0] pc_plus8D,
    input  logic              takenE,
    input  logic              stallD,
    input  logic              stallE,
    input  logic              flushD,
    input  logic              flushE,
    input  logic              flushM,
    output logic              pcsrcPD,
    output logic              branchM,
    output logic              pcsrcM,
    output logic              pcsrcPM,
    output logic              mispredictM,
    output logic [ADDR_W-1:0] redirect_pcM,
    output logic [31:0]       branch_cnt,
    output logic [31:0]       mispred_cnt
);

    // Same layout as br_info_t, sized to this instance's ADDR_W.
    typedef struct packed {
        logic              valid;
        logic              pred;
        logic              taken;
        logic [ADDR_W-1:0] target;
        logic [ADDR_W-1:0] pc_plus8;
    } stage_t;

    logic   pcsrcpd_r;
    stage_t de_d_s;
    stage_t de_q_s;
    stage_t em_d_s;
    stage_t em_q_s;
    logic   unused_s;

    // F->D prediction register: flush clears, otherwise stall holds.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pcsrcpd_r <= 1'b0;
        end else if (flushD) begin
            pcsrcpd_r <= 1'b0;
        end else if (!stallD) begin
            pcsrcpd_r <= pcsrcPF;
        end else begin
            pcsrcpd_r <= pcsrcpd_r;
        end
    end

    assign pcsrcPD = pcsrcpd_r;

    // D->E record: the outcome is not known yet in D, so taken starts at 0.
    always_comb begin
        de_d_s          = '0;
        de_d_s.valid    = branchD;
        de_d_s.pred     = pcsrcpd_r;
        de_d_s.taken    = 1'b0;
        de_d_s.target   = targetD;
        de_d_s.pc_plus8 = pc_plus8D;
    end

    bp_stage_reg #(
        .info_t (stage_t)
    ) u_de_reg (
        .clk   (clk),
        .rst_n (rst_n),
        .stall (stallE),
        .flush (flushE),
        .d     (de_d_s),
        .q     (de_q_s)
    );

    // E->M record: D->E fields plus the outcome evaluated in E.
    always_comb begin
        em_d_s       = de_q_s;
        em_d_s.taken = takenE;
    end

    // The D->E outcome bit is always overwritten by takenE before M.
    assign unused_s = de_q_s.taken;

    bp_stage_reg #(
        .info_t (stage_t)
    ) u_em_reg (
        .clk   (clk),
        .rst_n (rst_n),
        .stall (1'b0),
        .flush (flushM),
        .d     (em_d_s),
        .q     (em_q_s)
    );

    // M-stage resolution is purely from the E->M register, so a flushM in
    // the same cycle never masks what is currently in M.
    assign branchM      = em_q_s.valid;
    assign pcsrcPM      = em_q_s.pred;
    assign pcsrcM       = em_q_s.taken;
    assign mispredictM  = em_q_s.valid & (em_q_s.taken ^ em_q_s.pred);
    assign redirect_pcM = em_q_s.taken ? em_q_s.target : em_q_s.pc_plus8;

`ifdef BP_STATS_EN
    logic [31:0] branch_cnt_r;
    logic [31:0] mispred_cnt_r;

    // Saturating statistics counters sampled from the M-stage outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            branch_cnt_r  <= 32'd0;
            mispred_cnt_r <= 32'd0;
        end else begin
            if (branchM) begin
                branch_cnt_r <= sat_inc32(branch_cnt_r);
            end else begin
                branch_cnt_r <= branch_cnt_r;
            end
            if (mispredictM) begin
                mispred_cnt_r <= sat_inc32(mispred_cnt_r);
            end else begin
                mispred_cnt_r <= mispred_cnt_r;
            end
        end
    end

    assign branch_cnt  = branch_cnt_r;
    assign mispred_cnt = mispred_cnt_r;
`else
    assign branch_cnt  = 32'd0;
    assign mispred_cnt = 32'd0;
`endif

endmodule

// File: tb/tb_bp_resolve.sv
module tb_bp_resolve;

    localparam int AW = 32;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          pcsrcPF, branchD, takenE;
    logic [AW-1:0] targetD, pc_plus8D;
    logic          stallD, stallE, flushD, flushE, flushM;
    logic          pcsrcPD, branchM, pcsrcM, pcsrcPM, mispredictM;
    logic [AW-1:0] redirect_pcM;
    logic [31:0]   branch_cnt, mispred_cnt;

    int checks = 0;
    int errors = 0;

    // Reference model: what each stage holds, in instruction terms.
    logic          md_pred;
    logic          me_valid, me_pred;
    logic [AW-1:0] me_tgt, me_p8;
    logic          mm_valid, mm_pred, mm_taken;
    logic [AW-1:0] mm_tgt, mm_p8;
    logic [31:0]   exp_bc, exp_mc;

    bp_resolve #(.ADDR_W(AW)) dut (
        .clk(clk), .rst_n(rst_n), .pcsrcPF(pcsrcPF), .branchD(branchD),
        .targetD(targetD), .pc_plus8D(pc_plus8D), .takenE(takenE),
        .stallD(stallD), .stallE(stallE), .flushD(flushD), .flushE(flushE),
        .flushM(flushM), .pcsrcPD(pcsrcPD), .branchM(branchM), .pcsrcM(pcsrcM),
        .pcsrcPM(pcsrcPM), .mispredictM(mispredictM), .redirect_pcM(redirect_pcM),
        .branch_cnt(branch_cnt), .mispred_cnt(mispred_cnt)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] sat(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        md_pred = 1'b0;
        me_valid = 1'b0; me_pred = 1'b0; me_tgt = '0; me_p8 = '0;
        mm_valid = 1'b0; mm_pred = 1'b0; mm_taken = 1'b0; mm_tgt = '0; mm_p8 = '0;
        exp_bc = 32'd0; exp_mc = 32'd0;
    endtask

    // Advance the model by one clock using the inputs present at the edge.
    task automatic model_edge();
        if (!rst_n) begin
            model_reset();
        end else begin
`ifdef BP_STATS_EN
            if (mm_valid) exp_bc = sat(exp_bc);
            if (mm_valid && (mm_taken != mm_pred)) exp_mc = sat(exp_mc);
`endif
            if (flushM) begin
                mm_valid = 1'b0; mm_pred = 1'b0; mm_taken = 1'b0; mm_tgt = '0; mm_p8 = '0;
            end else begin
                mm_valid = me_valid; mm_pred = me_pred; mm_taken = takenE;
                mm_tgt = me_tgt; mm_p8 = me_p8;
            end
            if (flushE) begin
                me_valid = 1'b0; me_pred = 1'b0; me_tgt = '0; me_p8 = '0;
            end else if (!stallE) begin
                me_valid = branchD; me_pred = md_pred; me_tgt = targetD; me_p8 = pc_plus8D;
            end
            if (flushD) md_pred = 1'b0;
            else if (!stallD) md_pred = pcsrcPF;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic idle();
        pcsrcPF = 1'b0; branchD = 1'b0; takenE = 1'b0;
        targetD = '0; pc_plus8D = '0;
        stallD = 1'b0; stallE = 1'b0; flushD = 1'b0; flushE = 1'b0; flushM = 1'b0;
    endtask

    task automatic chk_all(input string tag);
        logic exp_mis;
        exp_mis = mm_valid & (mm_taken != mm_pred);
        check({tag, ".pcsrcPD"},  32'(pcsrcPD),     32'(md_pred));
        check({tag, ".branchM"},  32'(branchM),     32'(mm_valid));
        check({tag, ".pcsrcPM"},  32'(pcsrcPM),     32'(mm_pred));
        check({tag, ".pcsrcM"},   32'(pcsrcM),      32'(mm_taken));
        check({tag, ".mispred"},  32'(mispredictM), 32'(exp_mis));
        check({tag, ".redirect"}, redirect_pcM,     mm_taken ? mm_tgt : mm_p8);
        check({tag, ".bcnt"},     branch_cnt,       exp_bc);
        check({tag, ".mcnt"},     mispred_cnt,      exp_mc);
    endtask

    // One branch: guess in F, branch fields in D, outcome in E; ends in M.
    task automatic issue(input logic pf, input logic tk, input logic [AW-1:0] tgt,
                         input logic [AW-1:0] p8);
        pcsrcPF = pf; tick(); chk_all("iss0");
        pcsrcPF = 1'b0; branchD = 1'b1; targetD = tgt; pc_plus8D = p8;
        tick(); chk_all("iss1");
        branchD = 1'b0; takenE = tk; tick();
        takenE = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0;
        idle();
        model_reset();
        #12;
        chk_all("reset");
        @(posedge clk); #1;
        rst_n = 1'b1;

        // Correct taken prediction.
        issue(1'b1, 1'b1, 32'h0040_0100, 32'h0040_0008);
        chk_all("taken_ok");
        check("taken_ok.brM", 32'(branchM), 32'd1);
        check("taken_ok.pPM", 32'(pcsrcPM), 32'd1);
        check("taken_ok.pM",  32'(pcsrcM), 32'd1);
        check("taken_ok.mis", 32'(mispredictM), 32'd0);

        // Predicted taken, actually not taken.
        issue(1'b1, 1'b0, 32'h0040_0100, 32'h0040_0008);
        chk_all("mis_nt");
        check("mis_nt.mis", 32'(mispredictM), 32'd1);
        check("mis_nt.redir", redirect_pcM, 32'h0040_0008);

        // Same-cycle flushM: current M entry still reported.
        flushM = 1'b1; #1;
        check("flushM_same.mis", 32'(mispredictM), 32'd1);
        check("flushM_same.redir", redirect_pcM, 32'h0040_0008);
        tick(); flushM = 1'b0;
        chk_all("flushM_next");
        check("flushM_next.brM", 32'(branchM), 32'd0);

        // Asynchronous reset with a mispredict sitting in M.
        issue(1'b0, 1'b1, 32'h1234_5670, 32'h0000_0abc);
        check("pre_rst.mis", 32'(mispredictM), 32'd1);
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        check("async_rst.mis", 32'(mispredictM), 32'd0);
        check("async_rst.brM", 32'(branchM), 32'd0);
        chk_all("async_rst");
        @(posedge clk); #1;
        rst_n = 1'b1;
        pcsrcPF = 1'b1; branchD = 1'b1; takenE = 1'b1;
        tick(); chk_all("post_rst0");
        check("post_rst0.brM", 32'(branchM), 32'd0);
        idle();
        tick(); tick(); tick(); chk_all("post_rst_drain");

        // Stall in D for two cycles while the F guess toggles.
        pcsrcPF = 1'b1; tick();
        stallD = 1'b1; flushE = 1'b1; branchD = 1'b1; targetD = 32'h0000_2000;
        pc_plus8D = 32'h0000_1008; pcsrcPF = 1'b0;
        tick(); check("stall1.pPD", 32'(pcsrcPD), 32'd1); chk_all("stall1");
        pcsrcPF = 1'b1;
        tick(); check("stall2.pPD", 32'(pcsrcPD), 32'd1); chk_all("stall2");
        stallD = 1'b0; flushE = 1'b0; pcsrcPF = 1'b0;
        tick(); check("stall3.brM", 32'(branchM), 32'd0); chk_all("stall3");
        branchD = 1'b0; takenE = 1'b1;
        tick(); chk_all("stall4");
        check("stall4.brM", 32'(branchM), 32'd1);
        check("stall4.pPM", 32'(pcsrcPM), 32'd1);
        check("stall4.redir", redirect_pcM, 32'h0000_2000);
        idle();

        // flushE with a branch in D: no branchM afterwards.
        pcsrcPF = 1'b1; tick();
        pcsrcPF = 1'b0; branchD = 1'b1; flushE = 1'b1; tick();
        branchD = 1'b0; flushE = 1'b0; tick();
        check("flushE.brM2", 32'(branchM), 32'd0); chk_all("flushE2");
        tick();
        check("flushE.brM3", 32'(branchM), 32'd0); chk_all("flushE3");

        // Randomized traffic against the model, including back-to-back branches.
        for (int i = 0; i < 400; i++) begin
            pcsrcPF   = 1'($urandom_range(0, 1));
            branchD   = 1'($urandom_range(0, 1));
            takenE    = 1'($urandom_range(0, 1));
            targetD   = $urandom;
            pc_plus8D = $urandom;
            stallD    = ($urandom_range(0, 7) == 0);
            stallE    = ($urandom_range(0, 7) == 0);
            flushD    = ($urandom_range(0, 9) == 0);
            flushE    = ($urandom_range(0, 9) == 0);
            flushM    = ($urandom_range(0, 9) == 0);
            tick();
            chk_all("rnd");
        end
        idle();

`ifdef BP_STATS_EN
        // Counters preloaded just below saturation, then three mispredicts.
        rst_n = 1'b0; model_reset(); #1; rst_n = 1'b1;
        tick(); tick(); tick();
        dut.branch_cnt_r = 32'hFFFF_FFFE;
        dut.mispred_cnt_r = 32'hFFFF_FFFE;
        exp_bc = 32'hFFFF_FFFE;
        exp_mc = 32'hFFFF_FFFE;
        pcsrcPF = 1'b1; tick(); chk_all("cnt0");
        branchD = 1'b1; tick(); chk_all("cnt1");
        takenE = 1'b0; tick(); chk_all("cnt2");
        pcsrcPF = 1'b0; tick(); chk_all("cnt3");
        branchD = 1'b0; tick(); chk_all("cnt4");
        tick(); chk_all("cnt5");
        tick(); chk_all("cnt6");
        check("cnt.branch_sat", branch_cnt, 32'hFFFF_FFFF);
        check("cnt.mispred_sat", mispred_cnt, 32'hFFFF_FFFF);
`else
        check("cnt.branch_off", branch_cnt, 32'd0);
        check("cnt.mispred_off", mispred_cnt, 32'd0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
